serial_shift_controller: RTL and testbench

SERIAL_SHIFT_CONTROLLER -- requirements
Module: serial_shift_controller

---
 rtl/serial_shift_controller_pkg.sv | 17 +
 rtl/serial_shift_controller_bit_counter.sv | 53 +++++
 rtl/serial_shift_controller.sv | 127 ++++++++++++
 tb/tb_serial_shift_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_shift_controller_pkg.sv
// Shared definitions for the serial shift controller: FSM state encoding
// and the bit-counter width helper.
package serial_shift_controller_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Counter must hold WIDTH+LAT, the value reached after the last active cycle.
   function automatic int cnt_width(input int width, input int lat);
      return $clog2(width + lat + 1);
   endfunction

endpackage

// File: rtl/serial_shift_controller_bit_counter.sv
// Serial cycle counter: cleared on word acceptance, advances once per active
// serial cycle, and flags the last data bit, the last active cycle and the
// cycles in which returned data is valid.
module shift_bit_counter
   import serial_shift_controller_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LAT   = 4,
   parameter int CW    = cnt_width(WIDTH, LAT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          last_data_o,
   output logic          last_all_o,
   output logic          sample_o
);

   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_ALL  = CW'(WIDTH + LAT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear has priority over advance.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)   cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count_o     = cnt_q;
   assign last_data_o = (cnt_q == LAST_DATA);
   assign last_all_o  = (cnt_q == LAST_ALL);

   // Returned data is valid from cycle LAT onward; with no chain latency it
   // is valid from the first cycle.
   generate
      if (LAT == 0) begin : g_nolat
         assign sample_o = 1'b1;
      end else begin : g_lat
         assign sample_o = (cnt_q >= CW'(LAT));
      end
   endgenerate

endmodule

// File: rtl/serial_shift_controller.sv
// Serial shift controller: takes a parallel word, shifts it out LSB first on
// sdo, clocks the external chain for WIDTH+LAT cycles, reassembles the
// returned bits from sdi and presents the word with a valid/ready handshake.
module serial_shift_controller
   import serial_shift_controller_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LAT   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             sdo,
   output logic             shift_en,
   input  logic             sdi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH, LAT);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt;
   logic             last_data, last_all, sample;
   logic             accept, active, capture, final_bit;
   logic [WIDTH-1:0] tx_q, rx_q, out_data_q;
   logic             in_ready_q, sdo_q, shift_en_q, out_valid_q, busy_q;
   logic             in_ready_d, shift_en_d, out_valid_d, busy_d;

   assign accept    = (state_q == IDLE) && in_valid;
   assign active    = (state_q == SHIFT) || (state_q == FLUSH);
   // An aborted cycle never captures, so a cancelled word cannot disturb out_data.
   assign capture   = active && !abort && sample;
   assign final_bit = capture && last_all;

   shift_bit_counter #(.WIDTH(WIDTH), .LAT(LAT), .CW(CW)) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (accept),
      .en_i        (active),
      .count_o     (cnt),
      .last_data_o (last_data),
      .last_all_o  (last_all),
      .sample_o    (sample)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort only acts while the chain is being clocked.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (abort) state_d = IDLE;
                  else if (last_data) state_d = (LAT > 0) ? FLUSH : DONE;
         FLUSH:   if (abort) state_d = IDLE;
                  else if (last_all) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      shift_en_d  = (state_d == SHIFT) || (state_d == FLUSH);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_q  <= 1'b1;
         shift_en_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         shift_en_q  <= shift_en_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Transmit shifter and receive assembly. sdo is preloaded with bit 0 at
   // acceptance so the first bit appears in the first SHIFT cycle; received
   // bits collect in rx_q and reach out_data only on the final sample edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_q       <= '0;
         sdo_q      <= 1'b0;
         rx_q       <= '0;
         out_data_q <= '0;
      end else begin
         if (accept) begin
            tx_q  <= in_data;
            sdo_q <= in_data[0];
         end else if ((state_q == SHIFT) && (state_d == SHIFT)) begin
            tx_q  <= tx_q >> 1;
            sdo_q <= tx_q[1];
         end else begin
            sdo_q <= 1'b0;
         end
         if (capture)   rx_q       <= {sdi, rx_q[WIDTH-1:1]};
         if (final_bit) out_data_q <= {sdi, rx_q[WIDTH-1:1]};
      end
   end

   assign in_ready  = in_ready_q;
   assign sdo       = sdo_q;
   assign shift_en  = shift_en_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_shift_controller.sv
// Bench for serial_shift_controller: a LAT=4 instance looped back through a
// 4-stage chain clocked on shift_en, and a LAT=0 instance with sdo tied to sdi.
module tb_serial_shift_controller;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, LAT=4
   logic         va, ia_rdy, aa, sdoa, sena, sdia, ova, ora, busya;
   logic [W-1:0] da, oda;
   // Instance B: WIDTH=8, LAT=0
   logic         vb, ib_rdy, ab_b, sdob, senb, sdib, ovb, orb, busyb;
   logic [W-1:0] db, odb;

   serial_shift_controller #(.WIDTH(W), .LAT(4)) dut_a (
      .clk(clk), .reset(rst_n), .in_valid(va), .in_ready(ia_rdy), .in_data(da),
      .abort(aa), .sdo(sdoa), .shift_en(sena), .sdi(sdia), .out_valid(ova),
      .out_ready(ora), .out_data(oda), .busy(busya));

   serial_shift_controller #(.WIDTH(W), .LAT(0)) dut_b (
      .clk(clk), .reset(rst_n), .in_valid(vb), .in_ready(ib_rdy), .in_data(db),
      .abort(ab_b), .sdo(sdob), .shift_en(senb), .sdi(sdib), .out_valid(ovb),
      .out_ready(orb), .out_data(odb), .busy(busyb));

   // External 4-stage SISO chain, advanced only when shift_en is high.
   logic [3:0] chain;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)    chain <= 4'h0;
      else if (sena) chain <= {chain[2:0], sdoa};
   end
   assign sdia = chain[3];
   assign sdib = sdob;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] last_out;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every completed handshake on A must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && ova && ora) begin
         chk("sb_has_expected", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) chk("sb_out_data", oda, sb_q.pop_front());
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, ia_rdy, 1);
      chk({tag, "_sdo"}, sdoa, 0);
      chk({tag, "_shift_en"}, sena, 0);
      chk({tag, "_out_valid"}, ova, 0);
      chk({tag, "_busy"}, busya, 0);
      chk({tag, "_out_data"}, oda, 0);
   endtask

   // One word through A: sdo sequence, latency, optional out_ready stall, return to IDLE.
   // Starts and ends at posedge+1.
   task automatic xfer(input logic [W-1:0] d, input int hold, input bit ab,
                       input logic [W-1:0] exp_d, input int exp_lat);
      int n;
      n = 0;
      while (!ia_rdy && n < 40) begin step(); n++; end
      chk("in_ready_wait", ia_rdy, 1);
      va = 1'b1; da = d; ora = (hold == 0); aa = ab;
      step();
      va = 1'b0; da = ~d; aa = 1'b0;
      sb_q.push_back(exp_d);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("sdo_data_bit", sdoa, d[k]);
         chk("shift_en_shift", sena, 1);
         chk("in_ready_shift", ia_rdy, 0);
         step();
      end
      for (int k = W; k < exp_lat - 1; k++) begin
         @(negedge clk);
         chk("sdo_flush", sdoa, 0);
         chk("shift_en_flush", sena, 1);
         chk("out_valid_early", ova, 0);
         step();
      end
      aa = ab;
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         chk("out_valid_done", ova, 1);
         chk("in_ready_done", ia_rdy, 0);
         chk("shift_en_done", sena, 0);
         chk("out_data_held", oda, exp_d);
         step();
         if (h + 1 == hold) ora = 1'b1;
      end
      aa = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", ia_rdy, 1);
      chk("idle_busy", busya, 0);
      chk("idle_out_valid", ova, 0);
      last_out = exp_d;
      step();
   endtask

   typedef struct {
      logic [W-1:0] d;
      int           hold;
      bit           ab;
      logic [W-1:0] exp_d;
      int           exp_lat;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int cnt, t0, t1, acc, seen;
      tbl[0] = '{8'hA5, 0, 1'b0, 8'hA5, 13};
      tbl[1] = '{8'h3C, 0, 1'b1, 8'h3C, 13};
      tbl[2] = '{8'h00, 2, 1'b0, 8'h00, 13};
      tbl[3] = '{8'hFF, 1, 1'b1, 8'hFF, 13};
      tbl[4] = '{8'hA5, 5, 1'b0, 8'hA5, 13};
      tbl[5] = '{8'h81, 0, 1'b0, 8'h81, 13};

      va = 0; da = 0; aa = 0; ora = 1;
      vb = 0; db = 0; ab_b = 0; orb = 1;
      last_out = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      chk("reset_b_in_ready", ib_rdy, 1);
      chk("reset_b_out_data", odb, 0);
      step();
      rst_n = 1'b1;

      // Table-driven transfers on A.
      for (int i = 0; i < 6; i++)
         xfer(tbl[i].d, tbl[i].hold, tbl[i].ab, tbl[i].exp_d, tbl[i].exp_lat);

      // Abort at c=3 of 0xFF, then 0x81 must still complete.
      va = 1'b1; da = 8'hFF; ora = 1'b1;
      step();
      va = 1'b0;
      for (int k = 0; k < 3; k++) step();
      aa = 1'b1;
      step();
      aa = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", ia_rdy, 1);
      chk("abort_shift_en", sena, 0);
      chk("abort_sdo", sdoa, 0);
      chk("abort_busy", busya, 0);
      chk("abort_out_data", oda, last_out);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         @(negedge clk);
         if (ova) seen++;
      end
      chk("abort_no_out_valid", seen, 0);
      step();
      xfer(8'h81, 0, 1'b0, 8'h81, 13);

      // Reset pulsed at c=6 of 0xC3, then 0x5A accepted at the first edge after release.
      va = 1'b1; da = 8'hC3;
      step();
      va = 1'b0;
      for (int k = 0; k < 6; k++) step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      step();
      rst_n = 1'b1;
      xfer(8'h5A, 0, 1'b0, 8'h5A, 13);

      // LAT=0 loopback on B.
      vb = 1'b1; db = 8'h3C;
      step();
      vb = 1'b0;
      cnt = 0; seen = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (senb) cnt++;
         if (ovb && seen == 0) begin
            seen = i;
            chk("b_out_data", odb, 8'h3C);
         end
         step();
      end
      chk("b_shift_en_cycles", cnt, 8);
      chk("b_out_valid_cycle", seen, 9);

      // Back-to-back 0x01, 0x80 on A with in_valid held.
      va = 1'b1; da = 8'h01; ora = 1'b1;
      acc = 0; t0 = -1; t1 = -1;
      for (int i = 0; i < 60 && acc < 2; i++) begin
         @(negedge clk);
         if (ia_rdy) begin
            if (acc == 0) begin t0 = i; sb_q.push_back(8'h01); end
            else          begin t1 = i; sb_q.push_back(8'h80); end
            acc++;
         end
         step();
         if (acc == 1) da = 8'h80;
         if (acc == 2) va = 1'b0;
      end
      va = 1'b0;
      chk("b2b_accepts", acc, 2);
      chk("b2b_spacing", t1 - t0, 14);
      for (int k = 0; k < 20; k++) step();
      chk("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
